// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution datapath (MAC accumulator and
// requantizer). sat_add works on 64-bit containers so one function serves any width up to 63.
package conv_pkg;

  localparam int DEF_ACT_WIDTH = 8;
  localparam int DEF_WGT_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_PROD_W    = DEF_ACT_WIDTH + DEF_WGT_WIDTH;
  localparam int DEF_TAPS      = 9;
  localparam int DEF_NUM_OCH   = 16;
  localparam int DEF_OCH_W     = (DEF_NUM_OCH > 1) ? $clog2(DEF_NUM_OCH) : 1;
  localparam int SAT_MAX_W     = 64;

  typedef logic [DEF_OCH_W-1:0] och_idx_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        sat;
  } sat_res_t;

  // Adds two sign-extended operands and clamps to a signed range of the given width.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int                          width);
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t                  res;
    sum = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
    hi  = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (width - 1));
    if (sum > hi) begin
      res.value = hi[SAT_MAX_W-1:0];
      res.sat   = 1'b1;
    end else if (sum < lo) begin
      res.value = lo[SAT_MAX_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = sum[SAT_MAX_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Combinational multiply of one activation/weight pair plus saturating add onto the
// running accumulator. ACC_WIDTH must lie between ACT_WIDTH+WGT_WIDTH and 63.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int WGT_WIDTH = DEF_WGT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic signed [ACT_WIDTH-1:0] act,
  input  logic signed [WGT_WIDTH-1:0] wgt,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic signed [ACC_WIDTH-1:0] acc_next,
  output logic                        sat
);

  localparam int PROD_W = ACT_WIDTH + WGT_WIDTH;

  logic signed [PROD_W-1:0] product;
  sat_res_t                 res;
  logic                     unused_res_hi;

  assign product       = act * wgt;
  assign res           = sat_add(SAT_MAX_W'(product), SAT_MAX_W'(acc_in), ACC_WIDTH);
  assign acc_next      = res.value[ACC_WIDTH-1:0];
  assign sat           = res.sat;
  // Bits above ACC_WIDTH are always a sign copy after clamping.
  assign unused_res_hi = ^res.value[SAT_MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/conv_mac_accumulator.sv
// Streams int8 activation/weight pairs, accumulates TAPS products per window and emits
// one saturated sum per window tagged with its output-channel index (ready/valid both sides).
module conv_mac_accumulator
  import conv_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int WGT_WIDTH = DEF_WGT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int TAPS      = DEF_TAPS,
  parameter int NUM_OCH   = DEF_NUM_OCH,
  parameter int OCH_W     = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [ACT_WIDTH-1:0] act_in,
  input  logic signed [WGT_WIDTH-1:0] wgt_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] sum_out,
  output logic [OCH_W-1:0]            och_out,
  output logic                        last_och,
  output logic                        sat_flag
);

  localparam int               TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(NUM_OCH - 1);

  logic [TAP_W-1:0]            tap_cnt_q, tap_cnt_d;
  logic [OCH_W-1:0]            och_cnt_q, och_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  out_state_t                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [OCH_W-1:0]            och_q, och_d;
  logic                        last_q, last_d;
  logic                        sat_q, sat_d;

  logic                        is_last_tap;
  logic                        beat_acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] mac_acc_next;
  logic                        mac_sat;

  assign is_last_tap = (tap_cnt_q == TAP_LAST);
  // Only the last tap can stall, and only while an undrained result occupies the output.
  assign in_ready    = !rst && !clear &&
                       (!is_last_tap || (state_q == OUT_EMPTY) || out_ready);
  assign beat_acc    = in_valid && in_ready;
  assign acc_base    = (tap_cnt_q == '0) ? '0 : acc_q;

  conv_mac_sat #(
    .ACT_WIDTH (ACT_WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .act      (act_in),
    .wgt      (wgt_in),
    .acc_in   (acc_base),
    .acc_next (mac_acc_next),
    .sat      (mac_sat)
  );

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    tap_cnt_d = tap_cnt_q;
    och_cnt_d = och_cnt_q;
    acc_d     = acc_q;
    state_d   = state_q;
    sum_d     = sum_q;
    och_d     = och_q;
    last_d    = last_q;
    sat_d     = sat_q;

    if (clear) begin
      // sum/och/last keep stale values; only validity and counters are dropped.
      tap_cnt_d = '0;
      och_cnt_d = '0;
      state_d   = OUT_EMPTY;
      sat_d     = 1'b0;
    end else begin
      if ((state_q == OUT_FULL) && out_ready) begin
        state_d = OUT_EMPTY;
      end
      if (beat_acc) begin
        acc_d = mac_acc_next;
        sat_d = sat_q | mac_sat;
        if (is_last_tap) begin
          tap_cnt_d = '0;
          state_d   = OUT_FULL;
          sum_d     = mac_acc_next;
          och_d     = och_cnt_q;
          last_d    = (och_cnt_q == OCH_LAST);
          och_cnt_d = (och_cnt_q == OCH_LAST) ? '0 : och_cnt_q + 1'b1;
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt_q <= '0;
      och_cnt_q <= '0;
      acc_q     <= '0;
      state_q   <= OUT_EMPTY;
      sum_q     <= '0;
      och_q     <= '0;
      last_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      tap_cnt_q <= tap_cnt_d;
      och_cnt_q <= och_cnt_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      sum_q     <= sum_d;
      och_q     <= och_d;
      last_q    <= last_d;
      sat_q     <= sat_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign sum_out   = sum_q;
  assign och_out   = och_q;
  assign last_och  = last_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Scoreboard bench for conv_mac_accumulator: directed windows push expected results, a
// negedge monitor pops and compares; a second 16-bit-accumulator instance covers saturation.
module tb_conv_mac_accumulator;
  import conv_pkg::*;

  localparam int TAPS    = 9;
  localparam int NUM_OCH = 16;
  localparam int MAX_WAIT = 200;

  typedef struct {
    logic signed [31:0] sum;
    och_idx_t           och;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               clear, in_valid, in_ready, out_valid, out_ready, last_och, sat_flag;
  logic signed [7:0]  act_in, wgt_in;
  logic signed [31:0] sum_out;
  och_idx_t           och_out;

  logic               clear16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic               last_och16, sat_flag16;
  logic signed [7:0]  act16, wgt16;
  logic signed [15:0] sum16;
  och_idx_t           och16;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t               exp_q[$];
  logic signed [15:0] exp16_q[$];
  int                 exp_och = 0;

  conv_mac_accumulator #(.TAPS(TAPS), .NUM_OCH(NUM_OCH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .wgt_in(wgt_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .och_out(och_out), .last_och(last_och), .sat_flag(sat_flag)
  );

  conv_mac_accumulator #(.ACC_WIDTH(16), .TAPS(TAPS), .NUM_OCH(NUM_OCH)) dut16 (
    .clk(clk), .rst(rst), .clear(clear16), .in_valid(in_valid16), .in_ready(in_ready16),
    .act_in(act16), .wgt_in(wgt16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum_out(sum16), .och_out(och16), .last_och(last_och16), .sat_flag(sat_flag16)
  );

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input bit sel16, input logic signed [7:0] a,
                           input logic signed [7:0] w);
    int waited = 0;
    if (sel16) begin
      in_valid16 = 1'b1; act16 = a; wgt16 = w;
    end else begin
      in_valid = 1'b1; act_in = a; wgt_in = w;
    end
    @(negedge clk);
    while (!(sel16 ? in_ready16 : in_ready) && waited < MAX_WAIT) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= MAX_WAIT) fail_now("beat_accept");
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic push_exp(input logic signed [31:0] sum);
    exp_t e;
    e.sum  = sum;
    e.och  = och_idx_t'(exp_och);
    e.last = (exp_och == NUM_OCH - 1);
    exp_q.push_back(e);
    exp_och = (exp_och == NUM_OCH - 1) ? 0 : exp_och + 1;
  endtask

  task automatic send_window(input logic signed [7:0] a, input logic signed [7:0] w,
                             input logic signed [31:0] sum);
    push_exp(sum);
    for (int t = 0; t < TAPS; t++) send_beat(1'b0, a, w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor for the 32-bit instance, plus hold-stability under backpressure.
  logic               held = 1'b0;
  logic signed [31:0] held_sum;
  och_idx_t           held_och;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum_out, held_sum);
        check("hold_och", och_out, held_och);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("sum_out", sum_out, e.sum);
          check("och_out", och_out, e.och);
          check("last_och", last_och, e.last);
        end
      end
      held     = out_valid && !out_ready && !clear;
      held_sum = sum_out;
      held_och = och_out;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      if (exp16_q.size() == 0) fail_now("unexpected_output16");
      else check("sum_out16", sum16, exp16_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; act_in = '0; wgt_in = '0; out_ready = 1'b1;
    clear16 = 1'b0; in_valid16 = 1'b0; act16 = '0; wgt16 = '0; out_ready16 = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_och_out", och_out, 0);
    check("rst_last_och", last_och, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Basic window with latency check
    push_exp(18);
    for (int t = 0; t < TAPS; t++) begin
      send_beat(1'b0, 1, 2);
      if (t == TAPS - 2) check("lat_before_last", out_valid, 0);
    end
    check("lat_after_last", out_valid, 1);

    // Operand extremes
    send_window(-128, -128, 147456);
    send_window(-128, 127, -146304);
    idle(2);

    // Backpressure: window 3 held, window 4 last tap stalls until drain
    out_ready = 1'b0;
    send_window(3, 1, 27);
    push_exp(18);
    for (int t = 0; t < TAPS - 1; t++) send_beat(1'b0, 2, 1);
    in_valid = 1'b1; act_in = 2; wgt_in = 1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_no_bubble", out_valid, 1);
    idle(2);

    // clear mid-window with a result pending
    out_ready = 1'b0;
    send_window(1, 1, 9);
    for (int t = 0; t < 4; t++) send_beat(1'b0, 5, 5);
    clear = 1'b1; in_valid = 1'b1; act_in = 7; wgt_in = 7;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_sat_flag", sat_flag, 0);
    void'(exp_q.pop_back());
    exp_och   = 0;
    out_ready = 1'b1;
    send_window(1, 1, 9);
    idle(2);

    // Reset mid-window with a result pending
    out_ready = 1'b0;
    send_window(4, 1, 36);
    for (int t = 0; t < 3; t++) send_beat(1'b0, 6, 6);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 0);
    check("rstmid_sum_out", sum_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    exp_och   = 0;
    out_ready = 1'b1;
    idle(1);
    send_window(1, 1, 9);
    idle(2);

    // Channel wrap over 17 windows from a cleared counter
    clear = 1'b1;
    idle(1);
    clear   = 1'b0;
    exp_och = 0;
    for (int i = 0; i <= NUM_OCH; i++) send_window(8'(i), 1, 9 * i);
    idle(2);
    check("no_sat_32", sat_flag, 0);

    // Saturation on the 16-bit instance
    exp16_q.push_back(16'sd32767);
    for (int t = 0; t < TAPS; t++) send_beat(1'b1, -128, -128);
    idle(3);
    check("sat16_flag", sat_flag16, 1);
    clear16 = 1'b1;
    idle(1);
    clear16 = 1'b0;
    check("sat16_cleared", sat_flag16, 0);

    idle(20);
    check("queues_drained", exp_q.size() + exp16_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
